// File: rtl/zimbo_pkg.sv
// Shared constants and loader state encoding for the Zimbo program loader.
package zimbo_pkg;

  // Data word width shared with the core's memory interface.
  localparam int WORD_W = 16;

  // Default frame start marker.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_ADR_HI,
    ST_ADR_LO,
    ST_DAT_HI,
    ST_DAT_LO,
    ST_CSUM,
    ST_RUN
  } ldr_state_e;

endpackage

// File: rtl/zimbo_loader_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expire once LIMIT-1 idle cycles have already elapsed.
module ldr_timeout #(
  parameter int LIMIT = 65535
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and saturate at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/zimbo_loader.sv
// Serial program loader: parses framed bytes, writes 16-bit words to memory
// while holding the core in reset, then hands the memory port to the core.
module zimbo_loader
  import zimbo_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              core_reset_n,
  input  logic [WORD_W-1:0] core_addrm,
  input  logic [WORD_W-1:0] core_wmdata,
  input  logic              core_memwr_en,
  output logic [WORD_W-1:0] core_rmdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              load_done,
  output logic              err
);

  ldr_state_e        state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;      // words still to receive
  logic [WORD_W-1:0] addr_q, addr_d;    // next load address
  logic [7:0]        hi_q, hi_d;        // high byte of the word in flight
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic       accept, in_frame, run, expire;
  logic [7:0] sum_nxt;

  assign run      = (state_q == ST_RUN);
  assign in_frame = (state_q != ST_IDLE) && !run;
  assign rx_ready = !run;
  assign accept   = rx_valid && rx_ready;
  assign sum_nxt  = sum_q + rx_data;

  // Timer is held clear outside a frame, so entering IDLE also clears it.
  ldr_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (accept || !in_frame),
    .en      (in_frame),
    .expire  (expire)
  );

  // Frame parser: header capture, word assembly, checksum and abort handling.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            sum_d   = '0;
            err_d   = 1'b0;
            state_d = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          cnt_d[15:8] = rx_data;
          sum_d       = sum_nxt;
          state_d     = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          cnt_d[7:0] = rx_data;
          sum_d      = sum_nxt;
          state_d    = ST_ADR_HI;
        end
        ST_ADR_HI: begin
          addr_d[15:8] = rx_data;
          sum_d        = sum_nxt;
          state_d      = ST_ADR_LO;
        end
        ST_ADR_LO: begin
          addr_d[7:0] = rx_data;
          sum_d       = sum_nxt;
          state_d     = (cnt_q != '0) ? ST_DAT_HI : ST_CSUM;
        end
        ST_DAT_HI: begin
          hi_d    = rx_data;
          sum_d   = sum_nxt;
          state_d = ST_DAT_LO;
        end
        ST_DAT_LO: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {hi_q, rx_data};
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          sum_d   = sum_nxt;
          state_d = (cnt_q == WORD_W'(1)) ? ST_CSUM : ST_DAT_HI;
        end
        ST_CSUM: begin
          sum_d = sum_nxt;
          if (sum_nxt == 8'h00) begin
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end else if (in_frame && expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // Loader state and write-port registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory port mux: loader owns the port until RUN, then the core does.
  always_comb begin
    mem_addr  = run ? core_addrm    : waddr_q;
    mem_wdata = run ? core_wmdata   : wdata_q;
    mem_we    = run ? core_memwr_en : we_q;
  end

  assign core_rmdata  = mem_rdata;
  assign core_reset_n = run;
  assign load_done    = run;
  assign err          = err_q;

endmodule
